// File: rtl/mc_ctrl_pkg.sv
// Shared types for the multi-cycle MIPS main control: state encodings, opcodes,
// datapath select codes and the control word passed from the output decoder.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    typedef enum logic [1:0] {
        SRCB_REGB    = 2'b00,
        SRCB_FOUR    = 2'b01,
        SRCB_IMM     = 2'b10,
        SRCB_IMM_SH2 = 2'b11
    } srcb_t;

    typedef enum logic [1:0] {
        PCSRC_ALU    = 2'b00,
        PCSRC_ALUOUT = 2'b01,
        PCSRC_JUMP   = 2'b10
    } pcsrc_t;

    typedef struct packed {
        logic   iord;
        logic   mem_write;
        logic   ir_write;
        logic   reg_dst;
        logic   mem_to_reg;
        logic   reg_write;
        logic   alu_src_a;
        srcb_t  alu_src_b;
        aluop_t alu_op;
        pcsrc_t pc_src;
        logic   pc_write;
        logic   branch;
    } ctrl_word_t;

    // States that stall on mem_ready and are supervised by the watchdog.
    function automatic logic is_wait_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/mc_main_control_if.sv
// Control/datapath handshake bundle: instruction/flag inputs to the controller and
// the datapath selects and strobes it drives back.
interface mc_main_control_if;

    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       pc_en;
    logic       illegal_op;
    logic       mem_timeout;
    logic [3:0] state_o;

    modport master (
        input  opcode, zero, mem_ready,
        output iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
               alu_src_a, alu_src_b, alu_op, pc_src, pc_en,
               illegal_op, mem_timeout, state_o
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
               alu_src_a, alu_src_b, alu_op, pc_src, pc_en,
               illegal_op, mem_timeout, state_o
    );

endinterface

// File: rtl/mc_ctrl_outdec.sv
// Combinational state -> control word decode; FETCH load strobes wait for mem_ready.
module mc_ctrl_outdec
    import mc_ctrl_pkg::*;
(
    input  state_t     i_state,
    input  logic       i_mem_ready,
    output ctrl_word_t o_ctrl
);

    always_comb begin
        o_ctrl = '0;
        case (i_state)
            S_FETCH: begin
                o_ctrl.alu_src_b = SRCB_FOUR;
                o_ctrl.ir_write  = i_mem_ready;
                o_ctrl.pc_write  = i_mem_ready;
            end
            S_DECODE: begin
                o_ctrl.alu_src_b = SRCB_IMM_SH2;
            end
            S_MEMADR: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                o_ctrl.iord = 1'b1;
            end
            S_MEMWB: begin
                o_ctrl.mem_to_reg = 1'b1;
                o_ctrl.reg_write  = 1'b1;
            end
            S_MEMWR: begin
                o_ctrl.iord      = 1'b1;
                o_ctrl.mem_write = 1'b1;
            end
            S_EXEC: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                o_ctrl.reg_dst   = 1'b1;
                o_ctrl.reg_write = 1'b1;
            end
            S_BRANCH: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_op    = ALUOP_SUB;
                o_ctrl.pc_src    = PCSRC_ALUOUT;
                o_ctrl.branch    = 1'b1;
            end
            S_ADDIEX: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_IMM;
            end
            S_ADDIWB: begin
                o_ctrl.reg_write = 1'b1;
            end
            S_JUMP: begin
                o_ctrl.pc_src   = PCSRC_JUMP;
                o_ctrl.pc_write = 1'b1;
            end
            default: o_ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mc_main_control.sv
// Multi-cycle MIPS main control FSM: state register, opcode sequencing, memory-wait
// watchdog and sticky error flags; per-state outputs come from mc_ctrl_outdec.
module mc_main_control
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_MAX = 15
)
(
    input  logic              clk,
    input  logic              rst_n,
    mc_main_control_if.master bus
);

    // r_wd holds completed wait cycles, so expiry is the WAIT_MAX-th consecutive one.
    localparam logic [7:0] WD_LAST = 8'(WAIT_MAX - 1);

    state_t     r_state;
    logic [7:0] r_wd;
    logic       r_illegal;
    logic       r_timeout;

    logic       w_waiting;
    logic       w_expire;
    ctrl_word_t w_ctrl;

    assign w_waiting = is_wait_state(r_state) && !bus.mem_ready;
    assign w_expire  = w_waiting && (r_wd == WD_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_FETCH;
            r_wd      <= '0;
            r_illegal <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            if (w_waiting && !w_expire) begin
                r_wd <= r_wd + 8'd1;
            end else begin
                r_wd <= '0;
            end
            if (w_expire) begin
                r_timeout <= 1'b1;
            end
            case (r_state)
                S_FETCH: begin
                    if (bus.mem_ready) begin
                        r_state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    case (bus.opcode)
                        OP_LW, OP_SW: r_state <= S_MEMADR;
                        OP_RTYPE:     r_state <= S_EXEC;
                        OP_BEQ:       r_state <= S_BRANCH;
                        OP_ADDI:      r_state <= S_ADDIEX;
                        OP_J:         r_state <= S_JUMP;
                        default: begin
                            r_state   <= S_FETCH;
                            r_illegal <= 1'b1;
                        end
                    endcase
                end
                S_MEMADR: begin
                    r_state <= (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
                end
                S_MEMRD: begin
                    if (bus.mem_ready) begin
                        r_state <= S_MEMWB;
                    end else if (w_expire) begin
                        r_state <= S_FETCH;
                    end
                end
                S_MEMWR: begin
                    if (bus.mem_ready || w_expire) begin
                        r_state <= S_FETCH;
                    end
                end
                S_EXEC:   r_state <= S_ALUWB;
                S_ADDIEX: r_state <= S_ADDIWB;
                default:  r_state <= S_FETCH;
            endcase
        end
    end

    mc_ctrl_outdec u_outdec (
        .i_state     (r_state),
        .i_mem_ready (bus.mem_ready),
        .o_ctrl      (w_ctrl)
    );

    // Strobes are gated by rst_n directly so they drop the instant reset asserts.
    assign bus.mem_write   = rst_n & w_ctrl.mem_write;
    assign bus.ir_write    = rst_n & w_ctrl.ir_write;
    assign bus.reg_write   = rst_n & w_ctrl.reg_write;
    assign bus.pc_en       = rst_n & (w_ctrl.pc_write | (w_ctrl.branch & bus.zero));

    assign bus.iord        = w_ctrl.iord;
    assign bus.reg_dst     = w_ctrl.reg_dst;
    assign bus.mem_to_reg  = w_ctrl.mem_to_reg;
    assign bus.alu_src_a   = w_ctrl.alu_src_a;
    assign bus.alu_src_b   = w_ctrl.alu_src_b;
    assign bus.alu_op      = w_ctrl.alu_op;
    assign bus.pc_src      = w_ctrl.pc_src;
    assign bus.illegal_op  = r_illegal;
    assign bus.mem_timeout = r_timeout;
    assign bus.state_o     = r_state;

endmodule
